// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin byte arbiter feeding a hex display with a per-byte dwell window
module display_arbiter #(
  parameter int  NUM_REQ      = 4,
  parameter int  DWELL_CYCLES = 100000000,
  localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_byte,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 freeze,
  output logic [7:0]           hex_byte,
  output logic [ID_W-1:0]      active_id,
  output logic                 active,
  output logic                 dwell_done
);

  localparam logic [31:0]     LAST_CNT = 32'(DWELL_CYCLES - 1);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_run;
  logic [ID_W-1:0] r_win;
  logic [ID_W-1:0] r_last_id;
  logic [7:0]      r_hex;
  logic [ID_W-1:0] r_active_id;
  logic            r_active;
  logic            r_done;
  logic [31:0]     r_cnt;
  logic [ID_W-1:0] w_pick;
  logic            w_any;
  logic            w_xfer;
  logic            w_expire;
  int              w_idx;

  // Reset release is taken through one flop so the FSM first moves on the second edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // Round-robin search starting just after the last granted index, wrapping at NUM_REQ
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    w_idx  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(r_last_id) + k) % NUM_REQ;
      if (!w_any && req_valid[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx[ID_W-1:0];
      end
    end
  end

  // Next-state logic; req_ready is a one-cycle grant driven purely from the GRANT state
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    w_xfer    = 1'b0;
    w_expire  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_next = S_GRANT;
      end
      S_GRANT: begin
        req_ready[r_win] = 1'b1;
        w_xfer           = req_valid[r_win];
        w_next           = w_xfer ? S_SHOW : S_IDLE;
      end
      S_SHOW: begin
        if (!freeze && (r_cnt == LAST_CNT)) begin
          w_expire = 1'b1;
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_state <= S_IDLE;
    else if (r_run) r_state <= w_next;
  end

  // Winner latch, byte capture on transfer, and dwell counting while not frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win       <= '0;
      r_last_id   <= LAST_IDX;
      r_hex       <= 8'h00;
      r_active_id <= '0;
      r_active    <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
    end else if (r_run) begin
      r_done <= w_expire;
      if (r_state == S_IDLE && w_any) r_win <= w_pick;
      if (w_xfer) begin
        r_hex       <= req_byte[{r_win, 3'b000} +: 8];
        r_active_id <= r_win;
        r_last_id   <= r_win;
        r_active    <= 1'b1;
        r_cnt       <= '0;
      end
      if (r_state == S_SHOW && !freeze) begin
        if (w_expire) r_active <= 1'b0;
        else          r_cnt    <= r_cnt + 32'd1;
      end
    end
  end

  assign hex_byte   = r_hex;
  assign active_id  = r_active_id;
  assign active     = r_active;
  assign dwell_done = r_done;

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - self-checking bench for display_arbiter (NUM_REQ=4, DWELL_CYCLES=4)
module tb_display_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0] req_byte;
  logic [N-1:0]  req_ready;
  logic          freeze;
  logic [7:0]    hex_byte;
  logic [1:0]    active_id;
  logic          active;
  logic          dwell_done;

  display_arbiter #(.NUM_REQ(N), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_byte(req_byte),
    .req_ready(req_ready), .freeze(freeze), .hex_byte(hex_byte),
    .active_id(active_id), .active(active), .dwell_done(dwell_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Reference model: a pending winner, remaining unfrozen show cycles, and the displayed value
  int         m_pend;
  int         m_left;
  int         m_last;
  logic [7:0] m_hex;
  int         m_id;
  bit         m_done;
  bit         m_run;
  bit         m_nd;

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = -1; m_left = 0; m_last = N - 1; m_hex = 8'h00;
      m_id = 0; m_done = 0; m_run = 0;
    end else if (!m_run) begin
      m_run = 1;
    end else begin
      m_nd = 0;
      if (m_left > 0) begin
        if (!freeze) begin
          m_left--;
          if (m_left == 0) m_nd = 1;
        end
      end else if (m_pend >= 0) begin
        if (req_valid[m_pend]) begin
          m_hex  = req_byte[8*m_pend +: 8];
          m_id   = m_pend;
          m_last = m_pend;
          m_left = DW;
        end
        m_pend = -1;
      end else if (req_valid != '0) begin
        m_pend = rr_pick(m_last, req_valid);
      end
      m_done = m_nd;
    end
  end

  // Event log used by the directed checks
  int          ready_cnt;
  logic [N-1:0] last_ready;
  int          ready_cyc;
  int          done_cnt;
  logic [7:0]  rise_q[$];
  int          rise_cyc_q[$];
  int          len_q[$];
  int          done_cyc_q[$];
  int          cur_len;
  logic        prev_active;
  logic [N-1:0] exp_rdy;

  task automatic clear_mon();
    ready_cnt = 0; last_ready = '0; ready_cyc = 0; done_cnt = 0; cur_len = 0;
    rise_q.delete(); rise_cyc_q.delete(); len_q.delete(); done_cyc_q.delete();
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge
  always @(negedge clk) begin
    exp_rdy = (m_pend >= 0) ? 4'(1 << m_pend) : 4'b0000;
    chk("active",     {31'd0, active},     {31'd0, m_left > 0});
    chk("req_ready",  {28'd0, req_ready},  {28'd0, exp_rdy});
    chk("hex_byte",   {24'd0, hex_byte},   {24'd0, m_hex});
    chk("active_id",  {30'd0, active_id},  32'(m_id));
    chk("dwell_done", {31'd0, dwell_done}, {31'd0, m_done});
    if (req_ready != '0) begin ready_cnt++; last_ready = req_ready; ready_cyc = cyc; end
    if (dwell_done) begin done_cnt++; done_cyc_q.push_back(cyc); end
    if (active && !prev_active) begin rise_q.push_back(hex_byte); rise_cyc_q.push_back(cyc); end
    if (active) cur_len++;
    else if (prev_active) begin len_q.push_back(cur_len); cur_len = 0; end
    prev_active = active;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (ready_cnt == 0 && n < budget) begin @(negedge clk); #1; n++; end
    if (ready_cnt == 0) chk("wait_ready_timeout", 0, 1);
  endtask

  task automatic wait_rises(input int cnt, input int budget);
    int n = 0;
    while (rise_q.size() < cnt && n < budget) begin @(negedge clk); #1; n++; end
    if (rise_q.size() < cnt) chk("wait_rises_timeout", 32'(rise_q.size()), 32'(cnt));
  endtask

  int k0;

  initial begin
    prev_active = 0;
    clear_mon();
    rst_n = 0; req_valid = '0; req_byte = '0; freeze = 0;
    tick(3);
    rst_n = 1;

    // Idle after reset: nothing changes for 20 cycles
    tick(20);
    chk("t1_hex", {24'd0, hex_byte}, 32'h00);
    chk("t1_active", {31'd0, active}, 0);
    chk("t1_ready", {28'd0, req_ready}, 0);
    chk("t1_rises", 32'(rise_q.size()), 0);

    // Single request from index 2, with latency checks
    clear_mon();
    req_byte = 32'h00A5_0000;
    req_valid = 4'b0100; k0 = cyc;
    wait_ready(10);
    tick(1); req_valid = '0;
    tick(8);
    chk("t2_ready_cnt", 32'(ready_cnt), 1);
    chk("t2_ready_val", {28'd0, last_ready}, 32'h4);
    chk("t2_ready_lat", 32'(ready_cyc - k0), 1);
    chk("t2_active_lat", 32'(rise_cyc_q[0] - ready_cyc), 1);
    chk("t2_len", 32'(len_q[0]), 4);
    chk("t2_done_cnt", 32'(done_cnt), 1);
    chk("t2_hex", {24'd0, hex_byte}, 32'hA5);
    chk("t2_id", {30'd0, active_id}, 2);

    // Winner drops valid during the grant cycle: nothing captured
    clear_mon();
    req_byte = 32'h0000_3C00;
    req_valid = 4'b0010;
    wait_ready(10);
    req_valid = '0;
    tick(6);
    chk("t2b_rises", 32'(rise_q.size()), 0);
    chk("t2b_hex", {24'd0, hex_byte}, 32'hA5);
    chk("t2b_id", {30'd0, active_id}, 2);

    // Reset, then all four requesting: fair rotation from index 0
    rst_n = 0; tick(1); rst_n = 1;
    clear_mon();
    req_byte = 32'h4433_2211;
    req_valid = 4'b1111;
    wait_rises(5, 60);
    req_valid = '0;
    tick(8);
    chk("t3_seq0", {24'd0, rise_q[0]}, 32'h11);
    chk("t3_seq1", {24'd0, rise_q[1]}, 32'h22);
    chk("t3_seq2", {24'd0, rise_q[2]}, 32'h33);
    chk("t3_seq3", {24'd0, rise_q[3]}, 32'h44);
    chk("t3_seq4", {24'd0, rise_q[4]}, 32'h11);
    for (int i = 0; i < 4; i++) chk("t3_len", 32'(len_q[i]), 4);

    // Serve index 3 so last_id=3, then 1001 must grant 0 before 3
    clear_mon();
    req_byte = 32'hC300_005A;
    req_valid = 4'b1000;
    wait_ready(10);
    tick(1); req_valid = '0;
    tick(8);
    clear_mon();
    req_valid = 4'b1001;
    wait_rises(2, 40);
    req_valid = '0;
    tick(10);
    chk("t4_first", {24'd0, rise_q[0]}, 32'h5A);
    chk("t4_second", {24'd0, rise_q[1]}, 32'hC3);

    // Single requester held: back-to-back regrant, 2-cycle gap after dwell_done
    clear_mon();
    req_byte = 32'h0000_7E00;
    req_valid = 4'b0010;
    wait_rises(2, 40);
    req_valid = '0;
    tick(10);
    chk("t5_gap", 32'(rise_cyc_q[1] - done_cyc_q[0]), 2);
    chk("t5_hex", {24'd0, rise_q[1]}, 32'h7E);

    // Freeze for 10 cycles from the second show cycle: 14 active cycles, one pulse
    clear_mon();
    req_byte = 32'h0000_0099;
    req_valid = 4'b0001;
    wait_ready(10);
    tick(1); req_valid = '0;
    tick(1); freeze = 1;
    tick(10); freeze = 0;
    tick(10);
    chk("t6_len", 32'(len_q[0]), 14);
    chk("t6_done_cnt", 32'(done_cnt), 1);

    // Freeze raised in IDLE does not delay the grant; it stretches the window instead
    clear_mon();
    req_byte = 32'h0055_0000;
    req_valid = 4'b0100; freeze = 1; k0 = cyc;
    wait_ready(10);
    tick(1); req_valid = '0;
    tick(6); freeze = 0;
    tick(10);
    chk("t7_ready_lat", 32'(ready_cyc - k0), 1);
    chk("t7_len", 32'(len_q[0]), 10);
    chk("t7_done_cnt", 32'(done_cnt), 1);

    // Reset in the second show cycle, then restart from index 0 priority
    clear_mon();
    req_byte = 32'hB3B2_0000;
    req_valid = 4'b1100;
    wait_rises(1, 20);
    chk("t8_pre_hex", {24'd0, rise_q[0]}, 32'hB3);
    tick(1);
    rst_n = 0;
    #1;
    chk("t8_rst_active", {31'd0, active}, 0);
    chk("t8_rst_hex", {24'd0, hex_byte}, 32'h00);
    chk("t8_rst_id", {30'd0, active_id}, 0);
    chk("t8_rst_ready", {28'd0, req_ready}, 0);
    chk("t8_rst_done", {31'd0, dwell_done}, 0);
    tick(1);
    rst_n = 1; k0 = cyc;
    clear_mon();
    wait_ready(10);
    chk("t8_release_lat", 32'(ready_cyc - k0), 2);
    chk("t8_ready_val", {28'd0, last_ready}, 32'h4);
    wait_rises(1, 10);
    chk("t8_hex", {24'd0, rise_q[0]}, 32'hB2);
    req_valid = '0;
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
